// File: rtl/ascon_ctrl_fsm_pkg.sv
// Shared types and constants for the ASCON-128 sequencing controller.
package ascon_pack;

  localparam int NB_ROUNDS_PA   = 12;
  localparam int PB_FIRST_ROUND = 6;

  localparam logic [3:0] ROUND_LAST  = 4'(NB_ROUNDS_PA - 1);
  localparam logic [3:0] ROUND_PB_0  = 4'(PB_FIRST_ROUND);
  localparam logic [3:0] ROUND_ZERO  = 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_WAIT_AD = 3'd2,
    ST_AD      = 3'd3,
    ST_WAIT_PT = 3'd4,
    ST_PT      = 3'd5,
    ST_FINAL   = 3'd6,
    ST_DONE    = 3'd7
  } type_ctrl_state;

endpackage

// File: rtl/ascon_ctrl_fsm_round_counter.sv
// Round-constant index counter: loadable, increments by one, saturates at
// the last round so a late increment can never wrap back to round 0.
module round_counter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       inc_i,
  output logic [3:0] round_o,
  output logic       last_o
);

  logic [3:0] round_q;
  logic [3:0] round_d;

  // Next round index: load wins over increment, increment stops at the last round.
  always_comb begin
    round_d = round_q;
    if (load_i) begin
      round_d = (load_val_i > ROUND_LAST) ? ROUND_LAST : load_val_i;
    end else if (inc_i && (round_q != ROUND_LAST)) begin
      round_d = round_q + 4'd1;
    end
  end

  // Round register with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      round_q <= ROUND_ZERO;
    end else begin
      round_q <= round_d;
    end
  end

  assign round_o = round_q;
  assign last_o  = (round_q == ROUND_LAST);

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 encryption sequencer: drives the permutation enable, round index
// and the XOR/select controls of the datapath, one round per clock.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start_i, all outputs low
// INIT       | twelve initialisation rounds (IV||K||N loaded on round 0)
// WAIT_AD    | ready for an AD block; accept cycle runs round 6
// AD         | rounds 7..11 of an AD block
// WAIT_PT    | ready for a PT block; accept runs round 6 (or 0 if last)
// PT         | rounds 7..11 of a non-last PT block
// FINAL      | rounds 1..11 of finalisation, key XOR after round 11
// DONE       | tag valid for one cycle
module ascon_ctrl_fsm
  import ascon_pack::*;
#(
  parameter int NB_BLK_W = 4
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [NB_BLK_W-1:0] nb_ad_i,
  input  logic [NB_BLK_W-1:0] nb_pt_i,
  input  logic                data_valid_i,
  output logic                data_ready_o,
  output logic [3:0]          round_o,
  output logic                perm_en_o,
  output logic                init_sel_o,
  output logic                xor_data_b_o,
  output logic                xor_key_b_o,
  output logic                xor_key_e_o,
  output logic                xor_lsb_e_o,
  output logic                cipher_valid_o,
  output logic                tag_valid_o,
  output logic                busy_o
);

  localparam logic [NB_BLK_W-1:0] BLK_ZERO = '0;
  localparam logic [NB_BLK_W-1:0] BLK_ONE  = NB_BLK_W'(1);

  type_ctrl_state state_q, state_d;
  logic [NB_BLK_W-1:0] ad_cnt_q, ad_cnt_d;
  logic [NB_BLK_W-1:0] pt_cnt_q, pt_cnt_d;

  logic       rc_load;
  logic [3:0] rc_val;
  logic       rc_inc;
  logic [3:0] round_q;
  logic       rc_last;

  logic last_ad;
  logic last_pt;

  round_counter u_round_counter (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .load_i     (rc_load),
    .load_val_i (rc_val),
    .inc_i      (rc_inc),
    .round_o    (round_q),
    .last_o     (rc_last)
  );

  // A latched nb_pt of 0 is stored as 1, so "last" is a single compare.
  assign last_ad = (ad_cnt_q == BLK_ONE);
  assign last_pt = (pt_cnt_q == BLK_ONE);
  assign busy_o  = (state_q != ST_IDLE);

  // Next-state, counter updates and datapath strobes.
  always_comb begin
    state_d        = state_q;
    ad_cnt_d       = ad_cnt_q;
    pt_cnt_d       = pt_cnt_q;
    rc_load        = 1'b0;
    rc_val         = ROUND_ZERO;
    rc_inc         = 1'b0;
    data_ready_o   = 1'b0;
    round_o        = round_q;
    perm_en_o      = 1'b0;
    init_sel_o     = 1'b0;
    xor_data_b_o   = 1'b0;
    xor_key_b_o    = 1'b0;
    xor_key_e_o    = 1'b0;
    xor_lsb_e_o    = 1'b0;
    cipher_valid_o = 1'b0;
    tag_valid_o    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        round_o = ROUND_ZERO;
        if (start_i) begin
          ad_cnt_d = nb_ad_i;
          pt_cnt_d = (nb_pt_i == BLK_ZERO) ? BLK_ONE : nb_pt_i;
          rc_load  = 1'b1;
          rc_val   = ROUND_ZERO;
          state_d  = ST_INIT;
        end
      end

      ST_INIT: begin
        perm_en_o  = 1'b1;
        init_sel_o = (round_q == ROUND_ZERO);
        rc_inc     = 1'b1;
        if (rc_last) begin
          xor_key_e_o = 1'b1;
          xor_lsb_e_o = (ad_cnt_q == BLK_ZERO);
          rc_load     = 1'b1;
          rc_val      = ROUND_PB_0;
          state_d     = (ad_cnt_q != BLK_ZERO) ? ST_WAIT_AD : ST_WAIT_PT;
        end
      end

      ST_WAIT_AD: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          perm_en_o    = 1'b1;
          xor_data_b_o = 1'b1;
          rc_inc       = 1'b1;
          state_d      = ST_AD;
        end
      end

      ST_AD: begin
        perm_en_o = 1'b1;
        rc_inc    = 1'b1;
        if (rc_last) begin
          rc_load = 1'b1;
          rc_val  = ROUND_PB_0;
          if (last_ad) begin
            xor_lsb_e_o = 1'b1;
            state_d     = ST_WAIT_PT;
          end else begin
            ad_cnt_d = ad_cnt_q - BLK_ONE;
            state_d  = ST_WAIT_AD;
          end
        end
      end

      ST_WAIT_PT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          perm_en_o      = 1'b1;
          xor_data_b_o   = 1'b1;
          cipher_valid_o = 1'b1;
          if (last_pt) begin
            // Last block starts finalisation: this cycle is round 0 of pa.
            xor_key_b_o = 1'b1;
            round_o     = ROUND_ZERO;
            rc_load     = 1'b1;
            rc_val      = 4'd1;
            state_d     = ST_FINAL;
          end else begin
            rc_inc  = 1'b1;
            state_d = ST_PT;
          end
        end
      end

      ST_PT: begin
        perm_en_o = 1'b1;
        rc_inc    = 1'b1;
        if (rc_last) begin
          pt_cnt_d = pt_cnt_q - BLK_ONE;
          rc_load  = 1'b1;
          rc_val   = ROUND_PB_0;
          state_d  = ST_WAIT_PT;
        end
      end

      ST_FINAL: begin
        perm_en_o = 1'b1;
        rc_inc    = 1'b1;
        if (rc_last) begin
          xor_key_e_o = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        tag_valid_o = 1'b1;
        rc_load     = 1'b1;
        rc_val      = ROUND_ZERO;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and block-counter registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      ad_cnt_q <= BLK_ZERO;
      pt_cnt_q <= BLK_ZERO;
    end else begin
      state_q  <= state_d;
      ad_cnt_q <= ad_cnt_d;
      pt_cnt_q <= pt_cnt_d;
    end
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Scoreboard bench for ascon_ctrl_fsm: each encryption is expanded into a
// per-cycle list of expected controls, a monitor pops one entry per busy cycle.
module tb_ascon_ctrl_fsm;

  localparam int W = 4;

  localparam logic [8:0] F_READY = 9'b1_0000_0000;
  localparam logic [8:0] F_PERM  = 9'b0_1000_0000;
  localparam logic [8:0] F_INIT  = 9'b0_0100_0000;
  localparam logic [8:0] F_XDB   = 9'b0_0010_0000;
  localparam logic [8:0] F_XKB   = 9'b0_0001_0000;
  localparam logic [8:0] F_KE    = 9'b0_0000_1000;
  localparam logic [8:0] F_LSB   = 9'b0_0000_0100;
  localparam logic [8:0] F_CIPH  = 9'b0_0000_0010;
  localparam logic [8:0] F_TAG   = 9'b0_0000_0001;

  logic         clock_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         start_i = 1'b0;
  logic [W-1:0] nb_ad_i = '0;
  logic [W-1:0] nb_pt_i = '0;
  logic         data_valid_i = 1'b0;
  logic         data_ready_o;
  logic [3:0]   round_o;
  logic         perm_en_o;
  logic         init_sel_o;
  logic         xor_data_b_o;
  logic         xor_key_b_o;
  logic         xor_key_e_o;
  logic         xor_lsb_e_o;
  logic         cipher_valid_o;
  logic         tag_valid_o;
  logic         busy_o;

  ascon_ctrl_fsm #(.NB_BLK_W(W)) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .nb_ad_i        (nb_ad_i),
    .nb_pt_i        (nb_pt_i),
    .data_valid_i   (data_valid_i),
    .data_ready_o   (data_ready_o),
    .round_o        (round_o),
    .perm_en_o      (perm_en_o),
    .init_sel_o     (init_sel_o),
    .xor_data_b_o   (xor_data_b_o),
    .xor_key_b_o    (xor_key_b_o),
    .xor_key_e_o    (xor_key_e_o),
    .xor_lsb_e_o    (xor_lsb_e_o),
    .cipher_valid_o (cipher_valid_o),
    .tag_valid_o    (tag_valid_o),
    .busy_o         (busy_o)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [8:0] flags;
    logic [3:0] round;
    bit         rcare;
  } rec_t;

  rec_t  sb[$];
  rec_t  tmp[$];
  bit    valid_at[int];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    mon_en = 1'b0;
  string cur = "reset";

  // Monitor: every busy cycle consumes one expected entry; idle cycles must be all-zero.
  always @(negedge clock_i) begin : monitor
    logic [8:0] act;
    rec_t       e;
    act = {data_ready_o, perm_en_o, init_sel_o, xor_data_b_o, xor_key_b_o,
           xor_key_e_o, xor_lsb_e_o, cipher_valid_o, tag_valid_o};
    if (mon_en) begin
      n_cmp++;
      if (busy_o === 1'b1) begin
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL %s unexpected_busy cyc=%0d actual flags=%b round=%0d required idle",
                   cur, cyc, act, round_o);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || act !== e.flags || (e.rcare && round_o !== e.round)) begin
            n_bad++;
            $display("FAIL %s cycle_ctrl cyc=%0d actual flags=%b round=%0d required cyc=%0d flags=%b round=%0d(care=%0d)",
                     cur, cyc, act, round_o, e.cyc, e.flags, e.round, e.rcare);
          end
        end
      end else begin
        if (busy_o !== 1'b0 || act !== 9'd0 || round_o !== 4'd0) begin
          n_bad++;
          $display("FAIL %s idle_outputs cyc=%0d actual busy=%b flags=%b round=%0d required busy=0 flags=0 round=0",
                   cur, cyc, busy_o, act, round_o);
        end
      end
    end
  end

  task automatic add(input int c, input logic [8:0] f, input int r, input bit care);
    rec_t x;
    x.cyc   = c;
    x.flags = f;
    x.round = 4'(r);
    x.rcare = care;
    tmp.push_back(x);
  endtask

  // One encryption: build the expected schedule from the phase rules, then drive it.
  // ad_st/pt_st: stall cycles before each block of that phase, <0 means random 0..3.
  task automatic run(input string name, input int na, input int np_in,
                     input int ad_st, input int pt_st, input bit noise, input bit rst_mid);
    int k, t, done_c, end_c, cut, np, st;
    logic [8:0] f;
    cur = name;
    tmp.delete();
    valid_at.delete();
    k = cyc;
    t = k + 1;
    for (int r = 0; r < 12; r++) begin
      f = F_PERM;
      if (r == 0) f |= F_INIT;
      if (r == 11) begin
        f |= F_KE;
        if (na == 0) f |= F_LSB;
      end
      add(t, f, r, 1'b1);
      t++;
    end
    for (int b = 0; b < na; b++) begin
      st = (ad_st < 0) ? int'($urandom_range(0, 3)) : ad_st;
      for (int s = 0; s < st; s++) begin
        add(t, F_READY, 6, 1'b1);
        valid_at[t] = 1'b0;
        t++;
      end
      add(t, F_READY | F_PERM | F_XDB, 6, 1'b1);
      valid_at[t] = 1'b1;
      t++;
      for (int r = 7; r < 12; r++) begin
        f = F_PERM;
        if (r == 11 && b == na - 1) f |= F_LSB;
        add(t, f, r, 1'b1);
        t++;
      end
    end
    np = (np_in == 0) ? 1 : np_in;
    for (int b = 0; b < np; b++) begin
      st = (pt_st < 0) ? int'($urandom_range(0, 3)) : pt_st;
      for (int s = 0; s < st; s++) begin
        add(t, F_READY, 6, 1'b1);
        valid_at[t] = 1'b0;
        t++;
      end
      valid_at[t] = 1'b1;
      if (b == np - 1) begin
        add(t, F_READY | F_PERM | F_XDB | F_CIPH | F_XKB, 0, 1'b1);
        t++;
        for (int r = 1; r < 12; r++) begin
          add(t, (r == 11) ? (F_PERM | F_KE) : F_PERM, r, 1'b1);
          t++;
        end
      end else begin
        add(t, F_READY | F_PERM | F_XDB | F_CIPH, 6, 1'b1);
        t++;
        for (int r = 7; r < 12; r++) begin
          add(t, F_PERM, r, 1'b1);
          t++;
        end
      end
    end
    add(t, F_TAG, 0, 1'b0);
    done_c = t;
    // FINAL round 5 sits six cycles before FINAL round 11, which precedes DONE.
    cut   = rst_mid ? (done_c - 7) : (done_c + 1000);
    end_c = rst_mid ? (cut + 1) : (done_c + 1);
    foreach (tmp[i]) if (tmp[i].cyc <= cut) sb.push_back(tmp[i]);

    nb_ad_i      = W'(na);
    nb_pt_i      = W'(np_in);
    start_i      = 1'b1;
    data_valid_i = noise ? 1'($urandom & 1) : 1'b1;
    @(posedge clock_i); #1;
    while (cyc <= end_c) begin
      start_i = noise && (cyc <= done_c) && (cyc <= cut) && 1'($urandom & 1);
      reset_i = rst_mid && (cyc == cut);
      if (valid_at.exists(cyc)) data_valid_i = valid_at[cyc];
      else data_valid_i = noise ? 1'($urandom & 1) : 1'b1;
      if (noise) begin
        nb_ad_i = W'($urandom_range(0, 15));
        nb_pt_i = W'($urandom_range(0, 15));
      end
      @(posedge clock_i); #1;
    end
    reset_i = 1'b0;
    start_i = 1'b0;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s leftover_expected actual remaining=%0d required remaining=0 (first cyc=%0d)",
               name, sb.size(), sb[0].cyc);
    end
    sb.delete();
    repeat (2) begin
      @(posedge clock_i); #1;
    end
  endtask

  initial begin
    reset_i = 1'b1;
    repeat (3) @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    mon_en  = 1'b1;
    @(posedge clock_i); #1;

    run("baseline_1ad_1pt",  1, 1, 0, 0, 1'b0, 1'b0);
    run("no_ad_2pt",         0, 2, 0, 0, 1'b0, 1'b0);
    run("pt_stall_3",        1, 1, 0, 3, 1'b0, 1'b0);
    run("ignored_start_vld", 1, 1, 0, 0, 1'b1, 1'b0);
    run("nb_pt_zero",        0, 0, 0, 0, 1'b0, 1'b0);
    run("reset_final_r5",    2, 2, 1, 1, 1'b0, 1'b1);
    run("after_reset",       1, 1, 0, 0, 1'b0, 1'b0);
    run("max_blocks",       15, 2, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      run("random", int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), -1, -1,
          1'($urandom & 1), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
